// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central pipeline controller.
//   Arbitrates IF/ID/EX stall requests into a 6-bit stall vector, sequences
//   exception flushes (RUN -> FLUSH -> REFILL -> RUN) and flags stuck stalls.
// Optional feature: define STALL_PERF_EN to build the stall_cycles_o counter;
//   otherwise stall_cycles_o is tied to zero.
// Ports:
//   clk, rst (async, active-high)
//   stallreq_from_if/id/ex : stall requests, priority ex > id > if
//   excepttype_i, cp0_epc_i: exception type (0 = none, 0xe = eret) and EPC
//   stall_o                : bit0 PC .. bit5 WB, 1 = stop
//   flush_o, new_pc_o      : one-cycle flush pulse and redirect target
//   stall_timeout_o        : sticky stuck-stall flag
//   stall_cycles_o         : stall performance counter
module pipe_stall_ctrl #(
  parameter int unsigned MAX_STALL     = 64,
  parameter int unsigned REFILL_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [31:0] ExcEret    = 32'h0000000e;
  localparam logic [7:0]  MaxStall   = 8'(MAX_STALL);
  localparam logic [3:0]  RefillLoad = 4'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StFlush, StRefill} state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [3:0]  refill_q, refill_d;
  logic [7:0]  wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic [5:0]  stall_req;
  logic        exc_take;

  // MEM and WB are never stalled so downstream bubbles drain.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_from_ex) begin
      stall_req = 6'b001111;
    end else if (stallreq_from_id) begin
      stall_req = 6'b000111;
    end else if (stallreq_from_if) begin
      stall_req = 6'b000011;
    end
  end

  assign stall_o  = (state_q == StRun) ? stall_req : 6'b000000;
  assign exc_take = (state_q == StRun) && (excepttype_i != 32'h0);

  always_comb begin
    state_d   = state_q;
    flush_d   = 1'b0;
    new_pc_d  = new_pc_q;
    refill_d  = refill_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun: begin
        if (exc_take) begin
          // Exception wins over stalls; watchdog restarts on flush entry.
          state_d  = StFlush;
          flush_d  = 1'b1;
          new_pc_d = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
          wd_d     = 8'd0;
        end else if (stall_o != 6'b000000) begin
          if (wd_q < MaxStall) begin
            wd_d = wd_q + 8'd1;
          end
          if (wd_q == MaxStall - 8'd1) begin
            timeout_d = 1'b1;
          end
        end else begin
          wd_d = 8'd0;
        end
      end
      StFlush: begin
        state_d  = StRefill;
        refill_d = RefillLoad;
      end
      StRefill: begin
        if (refill_q == 4'd0) begin
          state_d = StRun;
        end else begin
          refill_d = refill_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'h0;
      refill_q  <= 4'd0;
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      refill_q  <= refill_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush_o         = flush_q;
  assign new_pc_o        = new_pc_q;
  assign stall_timeout_o = timeout_q;

`ifdef STALL_PERF_EN
  logic [31:0] perf_q;

  // Counts every stalled edge, including exception-accept cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'h0;
    end else if (stall_o != 6'b000000) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles_o = perf_q;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (default parameters).
// Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        req_if, req_id, req_ex;
  logic [31:0] excepttype;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] perf;

  int vectors = 0;
  int errs    = 0;

  pipe_stall_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (req_if),
    .stallreq_from_id (req_id),
    .stallreq_from_ex (req_ex),
    .excepttype_i     (excepttype),
    .cp0_epc_i        (epc),
    .stall_o          (stall),
    .flush_o          (flush),
    .new_pc_o         (new_pc),
    .stall_timeout_o  (timeout),
    .stall_cycles_o   (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_neg();
    @(negedge clk);
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] n);
`ifdef STALL_PERF_EN
    return n;
`else
    return 32'h0 & n;
`endif
  endfunction

  initial begin
    rst = 1'b1; req_if = 0; req_id = 0; req_ex = 0; excepttype = 0; epc = 0;
    #12;
    check("rst_stall", {26'h0, stall}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_newpc", new_pc, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    check("rst_perf", perf, 32'h0);
    next_neg(); rst = 1'b0;

    // Combinational priority, no clock edge in between.
    next_neg();
    req_id = 1; req_if = 1; #1;
    check("id_if", {26'h0, stall}, 32'h07);
    req_ex = 1; #1;
    check("ex_id_if", {26'h0, stall}, 32'h0f);
    req_ex = 0; req_id = 0; #1;
    check("if_only", {26'h0, stall}, 32'h03);
    req_if = 0; #1;
    check("idle", {26'h0, stall}, 32'h0);

    // Plain exception, held through FLUSH/REFILL to show it is ignored there.
    excepttype = 32'h1;
    next_neg(); #1;
    check("exc_flush", {31'h0, flush}, 32'h1);
    check("exc_newpc", new_pc, 32'h20);
    check("exc_stall", {26'h0, stall}, 32'h0);
    next_neg(); #1;
    check("refill_flush", {31'h0, flush}, 32'h0);
    check("refill_newpc", new_pc, 32'h20);
    next_neg(); #1;
    check("run_flush", {31'h0, flush}, 32'h0);
    excepttype = 32'h0;
    next_neg(); #1;
    check("run_flush2", {31'h0, flush}, 32'h0);

    // eret with EX stall held: stall follows requests in the accept cycle.
    excepttype = 32'he; epc = 32'h1234; req_ex = 1; #1;
    check("eret_stall_accept", {26'h0, stall}, 32'h0f);
    next_neg(); excepttype = 32'h0; #1;
    check("eret_flush", {31'h0, flush}, 32'h1);
    check("eret_newpc", new_pc, 32'h1234);
    check("eret_stall_flush", {26'h0, stall}, 32'h0);
    next_neg(); #1;
    check("eret_stall_refill", {26'h0, stall}, 32'h0);
    check("eret_flush_refill", {31'h0, flush}, 32'h0);
    next_neg(); #1;
    check("eret_stall_run", {26'h0, stall}, 32'h0f);
    check("perf_after_eret", perf, perf_exp(32'd1));
    req_ex = 0;

    // Watchdog: 64 consecutive stalled edges.
    next_neg(); req_ex = 1;
    for (int i = 0; i < 63; i++) next_neg();
    #1;
    check("wd_63", {31'h0, timeout}, 32'h0);
    next_neg(); #1;
    check("wd_64", {31'h0, timeout}, 32'h1);
    check("perf_wd", perf, perf_exp(32'd65));
    req_ex = 0;
    next_neg(); #1;
    check("wd_sticky", {31'h0, timeout}, 32'h1);
    check("wd_stall_off", {26'h0, stall}, 32'h0);

    // Reset in the middle of FLUSH.
    excepttype = 32'h1;
    next_neg(); excepttype = 32'h0; #1;
    check("pre_rst_flush", {31'h0, flush}, 32'h1);
    rst = 1; #1;
    check("mid_rst_flush", {31'h0, flush}, 32'h0);
    check("mid_rst_newpc", new_pc, 32'h0);
    check("mid_rst_timeout", {31'h0, timeout}, 32'h0);
    check("mid_rst_perf", perf, 32'h0);
    next_neg(); rst = 0;
    next_neg(); #1;
    check("post_rst_flush", {31'h0, flush}, 32'h0);
    req_id = 1; #1;
    check("post_rst_stall", {26'h0, stall}, 32'h07);
    req_id = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
